exe_stage_module: RTL and testbench
===================================

Name: exe_stage_module

Overview:
- Execute stage of the 5-stage ARM pipeline. It consumes the ID/EXE register outputs: control bits, exec_cmd, operand values, imm, shift_operand, signed_imm_24, dest and pc.
- Computes the ALU result, the second operand (Val2) and the branch target, and owns the NZCV status register, which it returns to the decode stage as sr.
- Drives branch_taken/branch_addr back to fetch and the IF/ID flush. Registers its results into the EXE/MEM pipeline register.

Parameters:
- ADDRESS_LEN, 32, pc and branch address width
- REGISTER_FILE_LEN, 32, operand and result width
- EXEC_COMMAND_LEN, 4, ALU command width
- SHIFT_OPERAND_LEN, 12, shift_operand width
- SIGNED_IMM_LEN, 24, branch offset width
- REGISTER_FILE_ADDRESS_LEN, 4, register index width and status register width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_en_in  in  1  writeback enable from ID/EXE
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- b  in  1  branch
- s  in  1  update status register
- exec_cmd  in  4  ALU command
- pc_in  in  32  pc+4 of the instruction
- val_r_n  in  32  Rn value
- val_r_m  in  32  Rm value (store data)
- imm  in  1  immediate operand select
- shift_operand  in  12  operand-2 field
- signed_imm_24  in  24  branch offset
- dest_in  in  4  destination register
- sr  out  4  status register {N,Z,C,V}, to the decode stage
- branch_taken  out  1  combinational; redirects fetch and flushes IF/ID and ID/EXE
- branch_addr  out  32  combinational branch target
- wb_en_out  out  1  registered
- mem_r_en_out  out  1  registered
- mem_w_en_out  out  1  registered
- alu_result  out  32  registered
- st_val  out  32  registered Rm value
- dest_out  out  4  registered

Behaviour:
- Reset (rst=0, asynchronous): sr=0000; wb_en_out, mem_r_en_out, mem_w_en_out=0; alu_result, st_val, dest_out=0.
- Latency: 1 cycle. Inputs present in cycle t appear on the registered outputs after rising edge t+1.
- Val2 is selected in this priority order:
  - imm=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - else if mem_r_en_in or mem_w_en_in: zero-extended shift_operand[11:0].
  - else: val_r_m shifted by shift_operand[11:7] with type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 returns val_r_m unchanged for every type. shift_operand[4] is ignored.
- ALU (cin = sr C bit):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: Rn+Val2
  - 0011 ADC: Rn+Val2+cin
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!cin
  - 0110 AND/TST: &
  - 0111 ORR: |
  - 1000 EOR: ^
  - Other codes: result 0, flags unchanged.
- Arithmetic is computed at 33 bits.
  - ADD/ADC: C = bit 32.
  - SUB/SBC: C = NOT borrow.
  - V: signed overflow of the operation.
  - Logical ops and MOV/MVN: C and V hold their previous values.
  - N = result[31]; Z = (result == 0).
- Status register: loaded at the rising edge when s=1 and b=0. When s=0 it holds.
- Branch:
  - branch_taken = b.
  - branch_addr = pc_in + (sign-extended signed_imm_24 << 2), wrapping modulo 2^32.
  - branch_taken is the flush source for the preceding stages.
  - A branch is not written back: wb_en_out=0 on a branch cycle.
- Store: st_val = val_r_m registered alongside alu_result (the effective address).
- Reset mid-operation: every register clears immediately, whatever the clock state.
- Consecutive instructions:
  - sr read by ADC/SBC is the value latched at the previous edge.
  - The updated flags are visible to the next instruction's condition check via sr.

Test Plan:
- Reset: hold rst=0 with random inputs -> sr=0000, all registered outputs 0, including mid-cycle assertion.
- ADD with flags: Rn=0x7FFFFFFF, imm=1, shift_operand=0x001, s=1, cmd 0010, dest 3 -> next edge alu_result=0x80000000, sr=1001 (N,V), dest_out=3, wb_en_out=1.
- SUB then SBC: Rn=5, Rm=5, LSL #0, SUB s=1 -> result 0, sr=0110. Then SBC Rn=10, Val2=3 -> result 7 (C=1, no extra borrow).
- Rotated immediate: shift_operand=0x4FF -> Val2=0xFF000000; MOV s=1 -> alu_result=0xFF000000, N=1.
- Shifts: Rm=0x80000001 with ASR #1 -> 0xC0000000; with ROR #4 -> 0x18000000; with LSR #31 -> 0x00000001.
- Branch and store:
  - pc_in=0x100, signed_imm_24=0xFFFFFE, b=1 -> branch_taken=1, branch_addr=0xF8, sr unchanged.
  - STR Rn=0x400, shift_operand=0x008, Rm=0xDEAD -> alu_result=0x408, st_val=0xDEAD, mem_w_en_out=1.

Source files
------------

// File: rtl/exe_stage_module.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage_module
//  Purpose  : ARM pipeline execute stage: Val2, ALU, NZCV, branch, EXE/MEM regs
//  Revision : 1.0
// ============================================================================
module exe_stage_module #(
    parameter int ADDRESS_LEN               = 32,
    parameter int REGISTER_FILE_LEN         = 32,
    parameter int EXEC_COMMAND_LEN          = 4,
    parameter int SHIFT_OPERAND_LEN         = 12,
    parameter int SIGNED_IMM_LEN            = 24,
    parameter int REGISTER_FILE_ADDRESS_LEN = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wb_en_in,
    input  logic                                 mem_r_en_in,
    input  logic                                 mem_w_en_in,
    input  logic                                 b,
    input  logic                                 s,
    input  logic [EXEC_COMMAND_LEN-1:0]          exec_cmd,
    input  logic [ADDRESS_LEN-1:0]               pc_in,
    input  logic [REGISTER_FILE_LEN-1:0]         val_r_n,
    input  logic [REGISTER_FILE_LEN-1:0]         val_r_m,
    input  logic                                 imm,
    input  logic [SHIFT_OPERAND_LEN-1:0]         shift_operand,
    input  logic [SIGNED_IMM_LEN-1:0]            signed_imm_24,
    input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in,
    output logic [REGISTER_FILE_ADDRESS_LEN-1:0] sr,
    output logic                                 branch_taken,
    output logic [ADDRESS_LEN-1:0]               branch_addr,
    output logic                                 wb_en_out,
    output logic                                 mem_r_en_out,
    output logic                                 mem_w_en_out,
    output logic [REGISTER_FILE_LEN-1:0]         alu_result,
    output logic [REGISTER_FILE_LEN-1:0]         st_val,
    output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out
);

    localparam int W = REGISTER_FILE_LEN;

    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_MOV = 4'b0001;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_MVN = 4'b1001;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_ADD = 4'b0010;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_ADC = 4'b0011;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_SUB = 4'b0100;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_SBC = 4'b0101;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_AND = 4'b0110;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_ORR = 4'b0111;
    localparam logic [EXEC_COMMAND_LEN-1:0] c_CMD_EOR = 4'b1000;

    logic [REGISTER_FILE_ADDRESS_LEN-1:0] r_sr_q;
    logic [REGISTER_FILE_ADDRESS_LEN-1:0] w_sr_d;
    logic                                 w_cin;

    logic [W-1:0]   w_imm_base;
    logic [4:0]     w_imm_rot;
    logic [4:0]     w_sh_amt;
    logic [2*W-1:0] w_imm_dbl;
    logic [2*W-1:0] w_rm_dbl;
    logic [W-1:0]   w_shifted;
    logic [W-1:0]   w_val2;

    logic [W:0]     w_sum;
    logic [W-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic           w_flags_valid;

    assign w_cin = r_sr_q[1];

    // Rotations use a doubled operand so a zero amount needs no special case.
    assign w_imm_base = {{(W-8){1'b0}}, shift_operand[7:0]};
    assign w_imm_rot  = {shift_operand[11:8], 1'b0};
    assign w_sh_amt   = shift_operand[11:7];
    assign w_imm_dbl  = {w_imm_base, w_imm_base} >> w_imm_rot;
    assign w_rm_dbl   = {val_r_m, val_r_m} >> w_sh_amt;

    always_comb begin
        w_shifted = val_r_m;
        case (shift_operand[6:5])
            2'b00:   w_shifted = val_r_m << w_sh_amt;
            2'b01:   w_shifted = val_r_m >> w_sh_amt;
            2'b10:   w_shifted = W'($signed(val_r_m) >>> w_sh_amt);
            default: w_shifted = w_rm_dbl[W-1:0];
        endcase
    end

    always_comb begin
        w_val2 = w_shifted;
        if (imm) begin
            w_val2 = w_imm_dbl[W-1:0];
        end else if (mem_r_en_in || mem_w_en_in) begin
            w_val2 = {{(W-SHIFT_OPERAND_LEN){1'b0}}, shift_operand};
        end
    end

    // Subtraction is Rn + ~Val2 + carry-in, so the carry out is directly NOT borrow.
    always_comb begin
        w_sum         = '0;
        w_res         = '0;
        w_c           = r_sr_q[1];
        w_v           = r_sr_q[0];
        w_flags_valid = 1'b1;
        case (exec_cmd)
            c_CMD_MOV: w_res = w_val2;
            c_CMD_MVN: w_res = ~w_val2;
            c_CMD_ADD, c_CMD_ADC: begin
                w_sum = {1'b0, val_r_n} + {1'b0, w_val2}
                      + {{W{1'b0}}, (exec_cmd == c_CMD_ADC) ? w_cin : 1'b0};
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (val_r_n[W-1] == w_val2[W-1]) && (w_res[W-1] != val_r_n[W-1]);
            end
            c_CMD_SUB, c_CMD_SBC: begin
                w_sum = {1'b0, val_r_n} + {1'b0, ~w_val2}
                      + {{W{1'b0}}, (exec_cmd == c_CMD_SBC) ? w_cin : 1'b1};
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
                w_v   = (val_r_n[W-1] != w_val2[W-1]) && (w_res[W-1] != val_r_n[W-1]);
            end
            c_CMD_AND: w_res = val_r_n & w_val2;
            c_CMD_ORR: w_res = val_r_n | w_val2;
            c_CMD_EOR: w_res = val_r_n ^ w_val2;
            default:   w_flags_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_sr_d = r_sr_q;
        if (s && !b && w_flags_valid) begin
            w_sr_d = {w_res[W-1], (w_res == '0), w_c, w_v};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr_q       <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_result   <= '0;
            st_val       <= '0;
            dest_out     <= '0;
        end else begin
            r_sr_q       <= w_sr_d;
            wb_en_out    <= wb_en_in && !b;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
            alu_result   <= w_res;
            st_val       <= val_r_m;
            dest_out     <= dest_in;
        end
    end

    assign sr           = r_sr_q;
    assign branch_taken = b;
    assign branch_addr  = pc_in + {{(ADDRESS_LEN-SIGNED_IMM_LEN-2){signed_imm_24[SIGNED_IMM_LEN-1]}},
                                   signed_imm_24, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_module.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage_module
//  Purpose  : Directed self-checking bench for exe_stage_module
//  Revision : 1.0
// ============================================================================
module tb_exe_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b, s, imm;
    logic [3:0]  exec_cmd;
    logic [31:0] pc_in, val_r_n, val_r_m;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest_in;
    logic [3:0]  sr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] alu_result, st_val;
    logic [3:0]  dest_out;

    int total  = 0;
    int passed = 0;

    exe_stage_module dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en_in      (wb_en_in),
        .mem_r_en_in   (mem_r_en_in),
        .mem_w_en_in   (mem_w_en_in),
        .b             (b),
        .s             (s),
        .exec_cmd      (exec_cmd),
        .pc_in         (pc_in),
        .val_r_n       (val_r_n),
        .val_r_m       (val_r_m),
        .imm           (imm),
        .shift_operand (shift_operand),
        .signed_imm_24 (signed_imm_24),
        .dest_in       (dest_in),
        .sr            (sr),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .wb_en_out     (wb_en_out),
        .mem_r_en_out  (mem_r_en_out),
        .mem_w_en_out  (mem_w_en_out),
        .alu_result    (alu_result),
        .st_val        (st_val),
        .dest_out      (dest_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b = 0; s = 0; imm = 0;
        exec_cmd = 4'b0000; pc_in = '0; val_r_n = '0; val_r_m = '0;
        shift_operand = '0; signed_imm_24 = '0; dest_in = '0;
    endtask

    // Present inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic clock_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b = 0; s = 1; imm = 1;
        exec_cmd = 4'($urandom_range(1, 8)); pc_in = $urandom; val_r_n = $urandom;
        val_r_m = $urandom; shift_operand = 12'($urandom); signed_imm_24 = 24'($urandom);
        dest_in = 4'hF;
        clock_in();
        clock_in();
        check("reset sr",         {28'b0, sr}, 32'h0);
        check("reset alu_result", alu_result, 32'h0);
        check("reset st_val",     st_val, 32'h0);
        check("reset dest_out",   {28'b0, dest_out}, 32'h0);
        check("reset ctrl",       {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);

        @(negedge clk);
        idle();
        rst = 1'b1;

        // ADD with signed overflow: 0x7FFFFFFF + 1
        @(negedge clk);
        idle();
        val_r_n = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; s = 1;
        exec_cmd = 4'b0010; dest_in = 4'd3; wb_en_in = 1;
        #1 check("add branch_taken", {31'b0, branch_taken}, 32'h0);
        clock_in();
        check("add result",  alu_result, 32'h8000_0000);
        check("add sr",      {28'b0, sr}, 32'h9);
        check("add dest",    {28'b0, dest_out}, 32'h3);
        check("add wb_en",   {31'b0, wb_en_out}, 32'h1);

        // SUB 5-5 register operand, LSL #0
        @(negedge clk);
        idle();
        val_r_n = 32'd5; val_r_m = 32'd5; s = 1; exec_cmd = 4'b0100;
        clock_in();
        check("sub result", alu_result, 32'h0);
        check("sub sr",     {28'b0, sr}, 32'h6);

        // SBC 10-3 with C=1: no extra borrow
        @(negedge clk);
        idle();
        val_r_n = 32'd10; imm = 1; shift_operand = 12'h003; exec_cmd = 4'b0101;
        clock_in();
        check("sbc result", alu_result, 32'd7);
        check("sbc sr hold", {28'b0, sr}, 32'h6);

        // ADC 1+1+C(1)
        @(negedge clk);
        idle();
        val_r_n = 32'd1; imm = 1; shift_operand = 12'h001; exec_cmd = 4'b0011;
        clock_in();
        check("adc result", alu_result, 32'd3);

        // MOV rotated immediate 0xFF ror 8; C,V keep 1,0
        @(negedge clk);
        idle();
        imm = 1; shift_operand = 12'h4FF; s = 1; exec_cmd = 4'b0001;
        clock_in();
        check("mov rot result", alu_result, 32'hFF00_0000);
        check("mov rot sr",     {28'b0, sr}, 32'hA);

        // Register shifts through MOV with s=0
        @(negedge clk);
        idle();
        val_r_m = 32'h8000_0001; exec_cmd = 4'b0001; shift_operand = 12'h0C0;
        clock_in();
        check("asr1", alu_result, 32'hC000_0000);
        @(negedge clk);
        shift_operand = 12'h260;
        clock_in();
        check("ror4", alu_result, 32'h1800_0000);
        @(negedge clk);
        shift_operand = 12'hFA0;
        clock_in();
        check("lsr31", alu_result, 32'h0000_0001);
        @(negedge clk);
        shift_operand = 12'h080;
        clock_in();
        check("lsl1", alu_result, 32'h0000_0002);
        check("shift sr hold", {28'b0, sr}, 32'hA);

        // Branch with s=1 and wb_en_in=1: sr and writeback must not change
        @(negedge clk);
        idle();
        b = 1; s = 1; wb_en_in = 1; exec_cmd = 4'b0010; imm = 1; shift_operand = 12'h001;
        pc_in = 32'h0000_0100; signed_imm_24 = 24'hFFFFFE;
        #1;
        check("branch taken", {31'b0, branch_taken}, 32'h1);
        check("branch addr",  branch_addr, 32'h0000_00F8);
        clock_in();
        check("branch sr",    {28'b0, sr}, 32'hA);
        check("branch wb_en", {31'b0, wb_en_out}, 32'h0);

        // STR: address from 12-bit offset, data from Rm
        @(negedge clk);
        idle();
        mem_w_en_in = 1; val_r_n = 32'h400; shift_operand = 12'h008;
        val_r_m = 32'h0000_DEAD; exec_cmd = 4'b0010; dest_in = 4'd7;
        clock_in();
        check("str addr",   alu_result, 32'h0000_0408);
        check("str st_val", st_val, 32'h0000_DEAD);
        check("str mem_w",  {30'b0, mem_r_en_out, mem_w_en_out}, 32'h1);

        // Carry out of ADD: 0xFFFFFFFF + 1
        @(negedge clk);
        idle();
        val_r_n = 32'hFFFF_FFFF; imm = 1; shift_operand = 12'h001; s = 1; exec_cmd = 4'b0010;
        clock_in();
        check("add carry result", alu_result, 32'h0);
        check("add carry sr",     {28'b0, sr}, 32'h6);

        // Undefined command: result 0, flags untouched even with s=1
        @(negedge clk);
        idle();
        val_r_n = 32'h8000_0000; imm = 1; shift_operand = 12'h001; s = 1; exec_cmd = 4'b1111;
        clock_in();
        check("undef result", alu_result, 32'h0);
        check("undef sr",     {28'b0, sr}, 32'h6);

        // Mid-cycle asynchronous reset after loading non-zero state
        @(negedge clk);
        idle();
        val_r_n = 32'h8000_0000; imm = 1; shift_operand = 12'h001; s = 1;
        exec_cmd = 4'b0010; dest_in = 4'd9; wb_en_in = 1; val_r_m = 32'h1234;
        clock_in();
        check("pre-reset result", alu_result, 32'h8000_0001);
        #2 rst = 1'b0;
        #1;
        check("async rst sr",     {28'b0, sr}, 32'h0);
        check("async rst result", alu_result, 32'h0);
        check("async rst st_val", st_val, 32'h0);
        check("async rst misc",   {27'b0, wb_en_out, dest_out}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
